// File: rtl/pc_fetch_unit_pkg.sv
// Shared types for the PC / instruction-fetch sequencer.
// State encodings, reset PC default and branch-type codes.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    BR_NB  = 3'b000,
    BR_BR  = 3'b001,
    BR_BMI = 3'b010,
    BR_BPL = 3'b011,
    BR_BZ  = 3'b100
  } br_type_e;

  function automatic logic word_aligned(
    input logic [1:0] lsb
  );
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_incrementer.sv
// Sequential-PC adder feeding the branch unit.
// Wraps modulo 2^ADDR_W.
module pc_incrementer #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_4
);

  assign pc_plus_4 = pc + ADDR_W'(4);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and fetch sequencer: FETCH -> WAIT -> EXEC, with
// terminal STOP on halt or misaligned branch target.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_4,
  input  logic [ADDR_W-1:0] npc,
  input  logic              exec_done,
  input  logic              halt,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       instret
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              imem_req_q, imem_req_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic [31:0]       instret_q, instret_d;

  pc_incrementer #(
    .ADDR_W(ADDR_W)
  ) u_inc (
    .pc       (pc_q),
    .pc_plus_4(pc_plus_4)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
    instret_d     = instret_q;
    unique case (state_q)
      ST_FETCH: begin
        if (!stall) begin
          state_d    = ST_WAIT;
          imem_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_valid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          instr_valid_d = 1'b0;
          // A misaligned target wins over halt and retires nothing.
          if (!word_aligned(npc[1:0])) begin
            fault_d = 1'b1;
            state_d = ST_STOP;
          end else begin
            pc_d      = npc;
            instret_d = instret_q + 32'd1;
            if (halt) begin
              halted_d = 1'b1;
              state_d  = ST_STOP;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_STOP: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      instret_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
      instret_q     <= instret_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed vectors push
// expected fetch addresses / instruction latches; a monitor checks.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [31:0] npc = '0;
  logic        exec_done = 1'b0;
  logic        halt = 1'b0;
  logic        halted;
  logic        fault;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } iexp_t;

  logic [31:0] req_q[$];
  iexp_t       ins_q[$];

  pc_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus_4  (pc_plus_4),
    .npc        (npc),
    .exec_done  (exec_done),
    .halt       (halt),
    .halted     (halted),
    .fault      (fault),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] a);
    req_q.push_back(a);
  endtask

  task automatic push_ins(input logic [31:0] i, p, c);
    iexp_t e;
    e.ins = i;
    e.pc  = p;
    e.pc4 = p + 32'd4;
    e.cnt = c;
    ins_q.push_back(e);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      tick();
      n++;
    end
    if (!imem_req) begin
      errors++;
      $display("FAIL wait_req: timeout got 0 expected 1");
    end
  endtask

  task automatic serve(input logic [31:0] d, input int lat);
    wait_req();
    repeat (lat - 1) tick();
    imem_valid = 1'b1;
    imem_rdata = d;
    tick();
    imem_valid = 1'b0;
    tick();
  endtask

  task automatic exec(input logic [31:0] t, input logic h);
    int n = 0;
    while (!instr_valid && n < 50) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      errors++;
      $display("FAIL wait_iv: timeout got 0 expected 1");
    end
    exec_done = 1'b1;
    npc       = t;
    halt      = h;
    tick();
    exec_done = 1'b0;
    halt      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic no_req_window(input string nm, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      tick();
      seen = seen | imem_req;
    end
    chk(nm, {31'd0, seen}, 32'd0);
  endtask

  // Monitor: compare on rising imem_req and rising instr_valid.
  initial begin
    logic pr = 1'b0;
    logic pv = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_req && !pr) begin
        if (req_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL req_unexp: addr %h expected none", imem_addr);
        end else begin
          chk("req_addr", imem_addr, req_q.pop_front());
        end
      end
      if (instr_valid && !pv) begin
        if (ins_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL iv_unexp: instr %h expected none", instr);
        end else begin
          iexp_t e;
          e = ins_q.pop_front();
          chk("instr", instr, e.ins);
          chk("pc", pc, e.pc);
          chk("pc_plus_4", pc_plus_4, e.pc4);
          chk("instret", instret, e.cnt);
        end
      end
      pr = imem_req;
      pv = instr_valid;
    end
  end

  initial begin
    // Phase A: reset state, first fetch, sequential flow
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_iv", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_flags", {30'd0, halted, fault}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    push_req(32'h0);
    rst = 1'b0;
    tick();
    chk("req_latency", {31'd0, imem_req}, 32'd1);
    push_ins(32'h1234_5678, 32'h0, 32'd0);
    serve(32'h1234_5678, 2);
    push_req(32'h4);
    exec(32'h4, 1'b0);
    push_ins(32'hA000_0001, 32'h4, 32'd1);
    serve(32'hA000_0001, 1);
    push_req(32'h8);
    exec(32'h8, 1'b0);
    push_ins(32'hA000_0002, 32'h8, 32'd2);
    serve(32'hA000_0002, 2);
    push_req(32'hC);
    exec(32'hC, 1'b0);
    push_ins(32'hA000_0003, 32'hC, 32'd3);
    serve(32'hA000_0003, 3);
    chk("seq_instret", instret, 32'd3);

    // Phase B: taken branch from 8, then misaligned target
    do_reset();
    push_req(32'h0);
    rst = 1'b0;
    push_ins(32'hB000_0000, 32'h0, 32'd0);
    serve(32'hB000_0000, 1);
    push_req(32'h4);
    exec(32'h4, 1'b0);
    push_ins(32'hB000_0004, 32'h4, 32'd1);
    serve(32'hB000_0004, 1);
    push_req(32'h8);
    exec(32'h8, 1'b0);
    push_ins(32'hB000_0008, 32'h8, 32'd2);
    serve(32'hB000_0008, 1);
    push_req(32'h1C);
    exec(32'h1C, 1'b0);
    chk("br_pc", pc, 32'h1C);
    chk("br_instret", instret, 32'd3);
    push_ins(32'hB000_001C, 32'h1C, 32'd3);
    serve(32'hB000_001C, 2);
    exec(32'h6, 1'b1);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_halted", {31'd0, halted}, 32'd0);
    chk("mis_pc", pc, 32'h1C);
    chk("mis_instret", instret, 32'd3);
    chk("mis_iv", {31'd0, instr_valid}, 32'd0);
    no_req_window("mis_noreq", 10);
    chk("mis_fault_hold", {31'd0, fault}, 32'd1);

    // Phase C: halt, stray pulses ignored
    do_reset();
    push_req(32'h0);
    rst = 1'b0;
    push_ins(32'hC000_0000, 32'h0, 32'd0);
    serve(32'hC000_0000, 2);
    exec(32'h20, 1'b1);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_fault", {31'd0, fault}, 32'd0);
    chk("halt_pc", pc, 32'h20);
    chk("halt_instret", instret, 32'd1);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    exec_done  = 1'b1;
    npc        = 32'h40;
    no_req_window("halt_noreq", 3);
    imem_valid = 1'b0;
    exec_done  = 1'b0;
    no_req_window("halt_noreq2", 5);
    chk("stray_pc", pc, 32'h20);
    chk("stray_instret", instret, 32'd1);
    chk("stray_instr", instr, 32'hC000_0000);
    chk("stray_iv", {31'd0, instr_valid}, 32'd0);

    // Phase D: stall, reset mid-WAIT, late response, wrap
    stall = 1'b1;
    do_reset();
    rst = 1'b0;
    no_req_window("stall_noreq", 5);
    push_req(32'h0);
    stall = 1'b0;
    tick();
    tick();
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    rst   = 1'b1;
    stall = 1'b1;
    tick();
    chk("midwait_req", {31'd0, imem_req}, 32'd0);
    rst        = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_valid = 1'b0;
    tick();
    chk("late_iv", {31'd0, instr_valid}, 32'd0);
    chk("late_instr", instr, 32'h0);
    push_req(32'h0);
    stall = 1'b0;
    push_ins(32'hD000_0000, 32'h0, 32'd0);
    serve(32'hD000_0000, 1);
    push_req(32'hFFFF_FFFC);
    exec(32'hFFFF_FFFC, 1'b0);
    push_ins(32'hD000_FFFC, 32'hFFFF_FFFC, 32'd1);
    serve(32'hD000_FFFC, 1);
    chk("wrap_pc4", pc_plus_4, 32'h0);

    tick();
    tick();
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("ins_q_empty", ins_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch sequencer for the multicycle core. It is the consumer side of the branch-resolution interface. It holds PC, presents pc_plus_4 to the branch unit, fetches from instruction memory with a valid handshake, and commits the returned npc when execute signals completion. It also tracks retired instructions, halt, and misaligned-target faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width; the instruction word is fixed at 32 bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  while high, no new fetch request is issued
imem_req  output  1  instruction-memory read request
imem_addr  output  ADDR_W  read address, equal to pc
imem_rdata  input  32  instruction word returned by memory
imem_valid  input  1  imem_rdata valid this cycle
instr  output  32  latched instruction register
instr_valid  output  1  high while instr is held for decode/execute
pc  output  ADDR_W  current PC
pc_plus_4  output  ADDR_W  pc + 4 modulo 2^ADDR_W, driven to the branch unit
npc  input  ADDR_W  next PC resolved by the branch unit
exec_done  input  1  one-cycle pulse: current instruction complete, npc valid
halt  input  1  sampled with exec_done: current instruction is a halt
halted  output  1  core stopped, terminal until reset
fault  output  1  misaligned npc detected, terminal until reset
instret  output  32  retired-instruction counter

Behaviour:
- States: FETCH, WAIT, EXEC, STOP.
- Reset:
  - pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, imem_req=0, halted=0, fault=0, instret=0.
  - Reset in any state, including mid-WAIT, takes priority over all other inputs.
  - A response for an aborted request (imem_valid arriving after reset) is ignored.
- FETCH:
  - If stall=0: go to WAIT; imem_req is registered high from the next cycle.
  - If stall=1: remain in FETCH with imem_req=0.
  - The first request is therefore visible 1 cycle after rst falls.
- WAIT:
  - imem_req=1 and imem_addr=pc, held stable until imem_valid is sampled high.
  - On imem_valid=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to EXEC.
  - Memory latency is unbounded; stall is ignored once in WAIT.
- EXEC:
  - instr_valid=1; pc and instr are held.
  - On exec_done=1 with npc[1:0]!=0: fault<=1, pc unchanged, instret unchanged, go to STOP.
  - On exec_done=1 with aligned npc: pc<=npc and instret<=instret+1 (wraps 2^32-1 -> 0), instr_valid<=0.
    - If halt=1, halted<=1 and go to STOP; otherwise go to FETCH.
  - A halt with a misaligned npc sets only fault.
- STOP: all outputs hold, imem_req=0, instr_valid=0; the only exit is rst.
- imem_valid outside WAIT and exec_done outside EXEC are ignored.
- pc_plus_4 is combinational from pc. pc=32'hFFFF_FFFC gives pc_plus_4=0.
- Minimum instruction period: FETCH(1) + WAIT(>=1) + EXEC(>=1) = 3 cycles.

Decomposition:
- Shared package/header: state encodings (FETCH=2'd0, WAIT=2'd1, EXEC=2'd2, STOP=2'd3), RESET_PC default, branch-type codes (NB=000, BR=001, BMI=010, BPL=011, BZ=100) for use by benches.
- One natural sub-module: pc_incrementer (pc -> pc_plus_4). Everything else is kept flat.

Test Plan:
1. Reset then release, memory returns 32'h1234_5678 two cycles after req → req high 1 cycle after reset release, imem_addr=0, instr=32'h1234_5678, instr_valid=1, pc_plus_4=4.
2. Sequential flow: exec_done with npc=pc_plus_4, three times → pc steps 0→4→8→C, instret=3, each fetch at the updated pc.
3. Taken branch: pc=8, exec_done with npc=8+4+32'h10 → next imem_addr=32'h1C, instret+1.
4. Misaligned target: exec_done with npc=32'h0000_0006 → fault=1, pc unchanged, instret unchanged, imem_req stays 0 forever.
5. Halt: exec_done=1 with halt=1 and npc=32'h20 → halted=1, pc=32'h20, no further requests; stray imem_valid/exec_done pulses change nothing.
6. Stall, reset mid-WAIT, and wrap:
   - stall=1 for 5 cycles in FETCH → no req.
   - Reset asserted during WAIT, late imem_valid ignored → refetch at RESET_PC.
   - Force pc=32'hFFFF_FFFC → pc_plus_4=0.
